vx_issue_sched: RTL and testbench
=================================

# vx_issue_sched

Per-core warp issue scheduler between the per-warp instruction buffers and the scoreboard/dispatch path. Each cycle it picks one eligible warp round-robin and pops that warp's head instruction. It then presents the selected warp id through a registered valid/ready output stage. A warp is eligible when its buffer head is valid, its operands are hazard-free and its target execution unit can accept work. Optional perf counters classify every cycle in which nothing was selected.

## Interface
- NUM_WARPS, 4: number of warps; a power of two, 2 or more.
- NUM_UNITS, 5: number of execution units (ALU, LSU, CSR, FPU, GPU).
- UNIT_BITS, 3: width of a unit index; equals clog2(NUM_UNITS).
- PERF_CTR_BITS, 44: width of each perf counter.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- warp_valid  in  NUM_WARPS  bit w is 1 when warp w's instruction buffer head is valid.
- warp_sb_ready  in  NUM_WARPS  bit w is 1 when the scoreboard reports no hazard for warp w's head instruction.
- warp_unit  in  NUM_WARPS*UNIT_BITS  target unit of warp w's head instruction, in slice [w*UNIT_BITS +: UNIT_BITS].
- unit_ready  in  NUM_UNITS  bit u is 1 when unit u accepts a request.
- warp_pop  out  NUM_WARPS  one-hot dequeue pulse to the instruction buffers.
- issue_valid  out  1  the output stage holds a scheduled warp.
- issue_wid  out  clog2(NUM_WARPS)  id of the scheduled warp.
- issue_ready  in  1  the downstream stage accepts the output.
- perf_sb_stalls, perf_unit_stalls, perf_out_stalls  out  PERF_CTR_BITS each  stall-cycle counters.

## Operation
- Output fire: issue_valid & issue_ready.
- Eligibility: elig[w] = warp_valid[w] & warp_sb_ready[w] & unit_ready[warp_unit[w]] & ~held[w].
  - held[w] = issue_valid & (issue_wid == w). The warp currently in the output stage is masked off, including in its fire cycle, because its instruction is not yet reserved in the scoreboard.
  - A warp_unit value of NUM_UNITS or above makes the warp ineligible.
- Stage free: ~issue_valid | issue_ready.
- Select: occurs when the stage is free and at least one elig bit is set.
  - Winner: the first set elig bit searching upward from rr_ptr, wrapping from NUM_WARPS-1 back to 0.
  - Next clock: warp_pop[winner]=1 (combinational, same cycle as select), issue_valid<=1, issue_wid<=winner, rr_ptr<=(winner+1) mod NUM_WARPS.
- Stage free with no eligible warp: warp_pop=0; issue_valid<=0 if it fired, otherwise it stays 0.
- Stage not free (issue_valid & ~issue_ready): issue_valid and issue_wid hold, warp_pop=0, rr_ptr holds.
- Stall classification, evaluated only when the stage is free and no select occurs; exactly one class per cycle, first match wins:
  1. No warp_valid bit set (ignoring held): idle, not counted.
  2. Some valid, unheld warp has warp_sb_ready set: unit stall.
  3. Otherwise: scoreboard stall.
- Output stall: counted on every cycle with issue_valid & ~issue_ready.

## Timing
- Reset values: issue_valid=0, issue_wid=0, rr_ptr=0, all perf counters 0. warp_pop is combinational and is 0 while reset is asserted.
- Latency: eligible warp to issue_valid is 1 cycle.
- Throughput: one issue per cycle when issue_ready stays high and eligible warps exist.
- Handshake: issue_wid is stable while issue_valid & ~issue_ready. issue_valid never drops without a fire.
- Reset asserted mid-operation discards the held entry. The popped instruction is lost; the instruction buffers reset at the same time.
- Counters wrap modulo 2^PERF_CTR_BITS.

## Configuration
- ISSUE_SCHED_PERF_EN defined: the three counters are implemented as above.
- ISSUE_SCHED_PERF_EN undefined: no counter flops are built and all three perf outputs are tied to 0. Scheduling behaviour is identical.

## Test plan
- Reset, then warp_valid=4'b1111 with all sb/unit ready and issue_ready=1 for 8 cycles: issue_wid sequence 0,1,2,3,0,1,2,3; exactly one warp_pop bit per cycle.
- issue_ready=0 for 3 cycles while issue_wid=2: issue_wid stays 2, warp_pop=0, perf_out_stalls increments by 3. After release, the next selection is warp 3.
- Only warp 1 valid, always ready: it issues once, then is masked while held. The output alternates valid/invalid, i.e. warp 1 issues every 2 cycles.
- warp_valid=4'b0001 with warp_sb_ready=0: nothing issues and perf_sb_stalls increments each cycle. Then set warp_sb_ready=1 with warp_unit[0]=1 and unit_ready[1]=0: perf_unit_stalls increments instead.
- Assert reset while issue_valid=1 and issue_wid=3: the next cycle shows issue_valid=0, and the first post-reset selection starts the search from warp 0.
- Build without ISSUE_SCHED_PERF_EN and rerun the first scenario: identical issue sequence, all perf outputs 0.

Source files
------------

// File: rtl/vx_issue_sched.sv
// Round-robin warp issue scheduler with a registered valid/ready output stage.
// Define ISSUE_SCHED_PERF_EN to build the stall-cycle perf counters.
module vx_issue_sched #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_UNITS     = 5,
  parameter int UNIT_BITS     = 3,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           warp_valid,
  input  logic [NUM_WARPS-1:0]           warp_sb_ready,
  input  logic [NUM_WARPS*UNIT_BITS-1:0] warp_unit,
  input  logic [NUM_UNITS-1:0]           unit_ready,
  output logic [NUM_WARPS-1:0]           warp_pop,
  output logic                           issue_valid,
  output logic [$clog2(NUM_WARPS)-1:0]   issue_wid,
  input  logic                           issue_ready,
  output logic [PERF_CTR_BITS-1:0]       perf_sb_stalls,
  output logic [PERF_CTR_BITS-1:0]       perf_unit_stalls,
  output logic [PERF_CTR_BITS-1:0]       perf_out_stalls
);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic             vld_q, vld_d;
  logic [WID_W-1:0] wid_q, wid_d, rr_q, rr_d, win;
  logic [NUM_WARPS-1:0] held, elig;
  logic             found, free, sel;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [UNIT_BITS-1:0] unit;
    logic                 ok;
    assign unit = warp_unit[w*UNIT_BITS +: UNIT_BITS];
    // Out-of-range unit ids match no ready bit and leave the warp ineligible.
    always_comb begin
      ok = 1'b0;
      for (int u = 0; u < NUM_UNITS; u++)
        if (unit == UNIT_BITS'(u)) ok = unit_ready[u];
    end
    // The warp sitting in the output stage is not yet reserved in the scoreboard.
    assign held[w] = vld_q && (wid_q == WID_W'(w));
    assign elig[w] = warp_valid[w] & warp_sb_ready[w] & ok & ~held[w];
  end

  always_comb begin
    logic [WID_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_q + WID_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign free = ~vld_q | issue_ready;
  assign sel  = free & found;

  always_comb begin
    warp_pop = '0;
    if (sel && !reset) warp_pop[win] = 1'b1;
  end

  always_comb begin
    vld_d = vld_q;
    wid_d = wid_q;
    rr_d  = rr_q;
    if (free) begin
      vld_d = found;
      if (found) begin
        wid_d = win;
        rr_d  = win + WID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      wid_q <= '0;
      rr_q  <= '0;
    end else begin
      vld_q <= vld_d;
      wid_q <= wid_d;
      rr_q  <= rr_d;
    end
  end

  assign issue_valid = vld_q;
  assign issue_wid   = wid_q;

`ifdef ISSUE_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] sb_q, unit_q, out_q;
  logic any_unit, no_sel;
  assign any_unit = |(warp_valid & warp_sb_ready & ~held);
  assign no_sel   = free & ~found & (|warp_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q   <= '0;
      unit_q <= '0;
      out_q  <= '0;
    end else begin
      if (no_sel && any_unit)  unit_q <= unit_q + PERF_CTR_BITS'(1);
      if (no_sel && !any_unit) sb_q   <= sb_q + PERF_CTR_BITS'(1);
      if (vld_q && !issue_ready) out_q <= out_q + PERF_CTR_BITS'(1);
    end
  end

  assign perf_sb_stalls   = sb_q;
  assign perf_unit_stalls = unit_q;
  assign perf_out_stalls  = out_q;
`else
  assign perf_sb_stalls   = '0;
  assign perf_unit_stalls = '0;
  assign perf_out_stalls  = '0;
`endif
endmodule

// File: tb/tb_vx_issue_sched.sv
// Bench for vx_issue_sched: directed scenarios plus random traffic against a
// cycle-level reference model of the scheduling rules.
module tb_vx_issue_sched;
  localparam int NW = 4;
  localparam int NU = 5;
  localparam int UB = 3;
  localparam int PB = 44;
`ifdef ISSUE_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NW-1:0] warp_valid, warp_sb_ready, warp_pop;
  logic [NW*UB-1:0] warp_unit;
  logic [NU-1:0] unit_ready;
  logic          issue_valid, issue_ready;
  logic [1:0]    issue_wid;
  logic [PB-1:0] perf_sb_stalls, perf_unit_stalls, perf_out_stalls;

  vx_issue_sched dut (
    .clk(clk), .reset(reset), .warp_valid(warp_valid), .warp_sb_ready(warp_sb_ready),
    .warp_unit(warp_unit), .unit_ready(unit_ready), .warp_pop(warp_pop),
    .issue_valid(issue_valid), .issue_wid(issue_wid), .issue_ready(issue_ready),
    .perf_sb_stalls(perf_sb_stalls), .perf_unit_stalls(perf_unit_stalls),
    .perf_out_stalls(perf_out_stalls)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (m_*) and its next value (n_*)
  bit            m_vld, n_vld;
  int            m_wid, n_wid, m_rr, n_rr;
  logic [PB-1:0] m_sb, m_un, m_out, n_sb, n_un, n_out;
  logic [NW-1:0] m_pop;

  function automatic logic [PB-1:0] pexp(input logic [PB-1:0] v);
    return PERF ? v : '0;
  endfunction

  // Let inputs settle, then derive this cycle's pop and next state from the rules.
  task automatic eval();
    int  win, u;
    bit  free, anyu, hw;
    #1;
    m_pop = '0;
    if (reset) begin
      n_vld = 0; n_wid = 0; n_rr = 0; n_sb = '0; n_un = '0; n_out = '0;
      return;
    end
    n_vld = m_vld; n_wid = m_wid; n_rr = m_rr; n_sb = m_sb; n_un = m_un; n_out = m_out;
    free = !m_vld || issue_ready;
    win = -1;
    anyu = 0;
    for (int k = 0; k < NW; k++) begin
      int w;
      w  = (m_rr + k) % NW;
      u  = int'(warp_unit[w*UB +: UB]);
      hw = m_vld && (m_wid == w);
      if (warp_valid[w] && warp_sb_ready[w] && !hw) anyu = 1;
      if (win < 0 && warp_valid[w] && warp_sb_ready[w] && !hw && u < NU && unit_ready[u]) win = w;
    end
    if (free) begin
      if (win >= 0) begin
        m_pop[win] = 1'b1;
        n_vld = 1; n_wid = win; n_rr = (win + 1) % NW;
      end else begin
        n_vld = 0;
        if (warp_valid != 0) begin
          if (anyu) n_un = m_un + 1;
          else      n_sb = m_sb + 1;
        end
      end
    end
    if (m_vld && !issue_ready) n_out = m_out + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_vld = n_vld; m_wid = n_wid; m_rr = n_rr; m_sb = n_sb; m_un = n_un; m_out = n_out;
  endtask

  task automatic drive_all_ready(input logic [NW-1:0] v);
    warp_valid = v; warp_sb_ready = '1; warp_unit = '0; unit_ready = '1; issue_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; eval(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_all_ready('1);
    eval();
    n_chk++; if (warp_pop !== 4'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0000", warp_pop); end
    step();
    n_chk++; if (issue_valid !== 1'b0 || issue_wid !== 2'd0) begin n_fail++;
      $display("FAIL reset_out: got valid=%b wid=%0d want 0/0", issue_valid, issue_wid); end
    n_chk++; if (perf_sb_stalls !== '0 || perf_unit_stalls !== '0 || perf_out_stalls !== '0) begin n_fail++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_sb_stalls, perf_unit_stalls, perf_out_stalls); end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    drive_all_ready(4'b1111);
    for (int i = 0; i < 8; i++) begin
      eval();
      n_chk++; if ($countones(warp_pop) != 1 || warp_pop !== m_pop) begin n_fail++;
        $display("FAIL rr_pop[%0d]: got %b want %b", i, warp_pop, m_pop); end
      step();
      n_chk++; if (issue_valid !== 1'b1 || issue_wid !== 2'(i % 4)) begin n_fail++;
        $display("FAIL rr_wid[%0d]: got valid=%b wid=%0d want 1/%0d", i, issue_valid, issue_wid, i % 4); end
    end
    n_chk++; if (perf_sb_stalls !== '0 || perf_unit_stalls !== '0 || perf_out_stalls !== '0) begin n_fail++;
      $display("FAIL rr_perf: got %0d/%0d/%0d want 0/0/0", perf_sb_stalls, perf_unit_stalls, perf_out_stalls); end
  endtask

  task automatic test_backpressure();
    logic [PB-1:0] base;
    do_reset();
    drive_all_ready(4'b1111);
    for (int i = 0; i < 3; i++) begin eval(); step(); end
    base = perf_out_stalls;
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eval();
      n_chk++; if (warp_pop !== 4'b0) begin n_fail++; $display("FAIL bp_pop[%0d]: got %b want 0000", i, warp_pop); end
      step();
      n_chk++; if (issue_valid !== 1'b1 || issue_wid !== 2'd2) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b wid=%0d want 1/2", i, issue_valid, issue_wid); end
    end
    n_chk++; if (perf_out_stalls !== pexp(base + 3)) begin n_fail++;
      $display("FAIL bp_outstall: got %0d want %0d", perf_out_stalls, pexp(base + 3)); end
    issue_ready = 1'b1;
    eval(); step();
    n_chk++; if (issue_valid !== 1'b1 || issue_wid !== 2'd3) begin n_fail++;
      $display("FAIL bp_release: got valid=%b wid=%0d want 1/3", issue_valid, issue_wid); end
  endtask

  task automatic test_single_warp();
    do_reset();
    drive_all_ready(4'b0010);
    for (int i = 0; i < 6; i++) begin
      eval(); step();
      n_chk++; if (issue_valid !== ((i % 2) == 0) || (issue_valid && issue_wid !== 2'd1)) begin n_fail++;
        $display("FAIL single[%0d]: got valid=%b wid=%0d want %0d/1", i, issue_valid, issue_wid, (i % 2) == 0); end
    end
  endtask

  task automatic test_stall_classes();
    logic [PB-1:0] sb0, un0;
    do_reset();
    drive_all_ready(4'b0001);
    warp_sb_ready = 4'b0000;
    sb0 = m_sb; un0 = m_un;
    for (int i = 0; i < 4; i++) begin
      eval();
      n_chk++; if (warp_pop !== 4'b0) begin n_fail++; $display("FAIL sb_pop[%0d]: got %b want 0000", i, warp_pop); end
      step();
    end
    n_chk++; if (perf_sb_stalls !== pexp(sb0 + 4) || perf_unit_stalls !== pexp(un0)) begin n_fail++;
      $display("FAIL sb_stall: got sb=%0d unit=%0d want %0d/%0d", perf_sb_stalls, perf_unit_stalls, pexp(sb0 + 4), pexp(un0)); end
    warp_sb_ready = 4'b1111; warp_unit = 12'h001; unit_ready = 5'b11101;
    for (int i = 0; i < 4; i++) begin eval(); step(); end
    n_chk++; if (perf_unit_stalls !== pexp(un0 + 4) || perf_sb_stalls !== pexp(sb0 + 4) || issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL unit_stall: got unit=%0d sb=%0d valid=%b want %0d/%0d/0", perf_unit_stalls, perf_sb_stalls,
               issue_valid, pexp(un0 + 4), pexp(sb0 + 4)); end
    // unit ids beyond the last unit never issue, even with every unit ready
    unit_ready = '1;
    for (int u = NU; u < 8; u++) begin
      warp_unit = 12'(u);
      eval(); step();
      n_chk++; if (issue_valid !== 1'b0 || perf_unit_stalls !== pexp(m_un)) begin n_fail++;
        $display("FAIL bad_unit[%0d]: got valid=%b unit=%0d want 0/%0d", u, issue_valid, perf_unit_stalls, pexp(m_un)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_all_ready(4'b1111);
    for (int i = 0; i < 4; i++) begin eval(); step(); end
    n_chk++; if (issue_valid !== 1'b1 || issue_wid !== 2'd3) begin n_fail++;
      $display("FAIL mid_pre: got valid=%b wid=%0d want 1/3", issue_valid, issue_wid); end
    reset = 1'b1;
    eval();
    n_chk++; if (warp_pop !== 4'b0) begin n_fail++; $display("FAIL mid_pop: got %b want 0000", warp_pop); end
    step();
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", issue_valid); end
    reset = 1'b0;
    eval(); step();
    n_chk++; if (issue_valid !== 1'b1 || issue_wid !== 2'd0) begin n_fail++;
      $display("FAIL mid_restart: got valid=%b wid=%0d want 1/0", issue_valid, issue_wid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      warp_valid    = 4'($urandom);
      warp_sb_ready = 4'($urandom | $urandom);
      warp_unit     = 12'($urandom);
      unit_ready    = 5'($urandom | $urandom);
      issue_ready   = ($urandom_range(3) != 0);
      eval();
      n_chk++; if (warp_pop !== m_pop) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %b want %b", i, warp_pop, m_pop); end
      step();
      n_chk++; if (issue_valid !== m_vld || (m_vld && issue_wid !== 2'(m_wid))) begin n_fail++;
        $display("FAIL rnd_out[%0d]: got valid=%b wid=%0d want %b/%0d", i, issue_valid, issue_wid, m_vld, m_wid); end
      n_chk++; if (perf_sb_stalls !== pexp(m_sb) || perf_unit_stalls !== pexp(m_un) || perf_out_stalls !== pexp(m_out)) begin
        n_fail++;
        $display("FAIL rnd_perf[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, perf_sb_stalls, perf_unit_stalls,
                 perf_out_stalls, pexp(m_sb), pexp(m_un), pexp(m_out)); end
    end
  endtask

  initial begin
    reset = 1'b1; warp_valid = '0; warp_sb_ready = '0; warp_unit = '0; unit_ready = '0; issue_ready = 1'b0;
    m_vld = 0; m_wid = 0; m_rr = 0; m_sb = '0; m_un = '0; m_out = '0;
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_warp();
    test_stall_classes();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
